ezm_prog_feeder: RTL and testbench
==================================

Name: ezm_prog_feeder

Overview:
Program-memory and sequencing stage directly upstream of the ezm_cpu core. A host loads a program of 6-bit instruction words over a valid/ready write port. The block then releases the CPU from reset and drives the CPU instruction input (in_i) from memory, indexed by the CPU program counter. It detects run-off past the loaded program, and reports run status and a cycle count.

Parameters:
ADDR_W, 5, instruction memory address width; DEPTH = 2**ADDR_W words of 6 bits.
NOP_WORD, 6'b000000, word driven on instr_o whenever no valid instruction applies (a no-op for the core).

Ports:
clk  in  1  clock; same clock as the CPU core.
rst  in  1  reset, synchronous, active-high.
load_start  in  1  pulse: enter/restart LOAD, clear program.
run_start  in  1  pulse: leave LOAD and start execution.
stop  in  1  pulse: abort LOAD/RUN/HALT, return to IDLE.
wr_valid  in  1  host write data valid.
wr_data  in  6  instruction word to store.
wr_ready  out  1  block accepts a word this cycle.
pc_i  in  8  CPU program counter.
instr_o  out  6  instruction to CPU in_i.
cpu_rst_o  out  1  active-high reset to CPU core.
running  out  1  state == RUN.
halted  out  1  state == HALT.
prog_len_o  out  ADDR_W+1  number of words loaded (0..DEPTH).
cycle_cnt_o  out  16  clock cycles spent in RUN since last entry.
checksum_o  out  8  program checksum (see Optional Feature).

Behaviour:
- States: IDLE, LOAD, RUN, HALT. All state and registers update on posedge clk only.
- Reset (rst=1 at posedge):
  - state=IDLE, prog_len=0, wr_ptr=0, cycle_cnt=0, checksum=0.
  - Memory contents are not cleared.
  - Output values under reset: wr_ready=0, instr_o=NOP_WORD, cpu_rst_o=1, running=0, halted=0, prog_len_o=0, cycle_cnt_o=0.
  - rst mid-LOAD or mid-RUN aborts immediately with the same values.
- Priority per cycle: rst > stop > load_start > run_start > write/run activity.
- IDLE:
  - load_start -> LOAD, with wr_ptr=0 and prog_len=0.
  - run_start is ignored.
- LOAD:
  - wr_ready = (prog_len < DEPTH). Combinational; no dependence on wr_valid.
  - A word is accepted when wr_valid & wr_ready: mem[wr_ptr] <= wr_data, wr_ptr and prog_len increment. The word is readable the next cycle.
  - Full: at prog_len == DEPTH, wr_ready=0 and further writes are dropped. No wrap.
  - load_start in LOAD restarts: pointer and length are cleared. A write in that same cycle is discarded.
  - run_start with prog_len_next > 0 -> RUN. A write accepted in the same cycle counts toward the length and is executed.
  - run_start with prog_len_next == 0 is ignored; the block stays in LOAD.
- RUN:
  - cpu_rst_o=0 from the first RUN cycle. cycle_cnt is cleared on entry, then +1 per cycle, saturating at 16'hFFFF.
  - instr_o is combinational, zero-latency: mem[pc_i[ADDR_W-1:0]] when pc_i < prog_len, else NOP_WORD. This is required because the core samples in_i on the same edge that advances pc.
  - pc_i >= prog_len sampled at a posedge -> HALT. The backward-branch case (pc wrapping to a large value) is covered by the same 8-bit unsigned compare.
- HALT:
  - instr_o=NOP_WORD, cpu_rst_o stays 0 so CPU state remains observable.
  - cycle_cnt is frozen.
  - load_start -> LOAD (cpu_rst_o=1). run_start -> RUN (cycle_cnt cleared, program unchanged).
- stop from any state -> IDLE: cpu_rst_o=1, instr_o=NOP_WORD. prog_len and memory are retained.
- cpu_rst_o=1 in IDLE and LOAD.
- wr_ready=0 in every state other than LOAD.

Optional Feature:
- Macro EZM_FEEDER_CHECKSUM_EN.
- Defined: checksum_o is an 8-bit modulo-256 sum of zero-extended accepted words. It is cleared on rst and on any load_start, updated in the write cycle, and visible the next cycle.
- Undefined: checksum_o is constant 8'h00 and no checksum logic is built.

Test Plan:
1. rst=1 for 2 cycles -> cpu_rst_o=1, instr_o=6'h00, wr_ready=0, prog_len_o=0, cycle_cnt_o=0.
2. load_start, then write 6'b100011, 6'b001000, 6'b010000, then run_start -> prog_len_o=3; RUN entered.
   - pc_i=0,1,2 -> instr_o = 6'h23, 6'h08, 6'h10.
   - pc_i=3 -> instr_o=6'h00, then halted=1 next cycle.
   - cycle_cnt_o frozen at 4.
3. In LOAD, hold wr_valid=1 for DEPTH+3 cycles -> exactly 32 words accepted, wr_ready=0 after the 32nd, prog_len_o=32, no overwrite of mem[0].
4. run_start with prog_len=0 -> stays in LOAD, cpu_rst_o=1.
   - Then write plus run_start in the same cycle -> RUN with prog_len_o=1.
5. stop during RUN at cycle_cnt=10 -> IDLE next cycle, cpu_rst_o=1, prog_len_o unchanged.
   - rst during LOAD -> prog_len_o=0.
6. With EZM_FEEDER_CHECKSUM_EN: load 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F -> checksum_o=8'h3B.
   - Without the macro -> checksum_o=8'h00.

Source files
------------

// File: rtl/ezm_prog_feeder.sv
// Program memory and run sequencer feeding the ezm_cpu instruction input.
// Optional build macro EZM_FEEDER_CHECKSUM_EN adds a running checksum of loaded words.
module ezm_prog_feeder #(
    parameter int unsigned ADDR_W   = 5,
    parameter logic [5:0]  NOP_WORD = 6'b000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              stop,
    input  logic              wr_valid,
    input  logic [5:0]        wr_data,
    output logic              wr_ready,
    input  logic [7:0]        pc_i,
    output logic [5:0]        instr_o,
    output logic              cpu_rst_o,
    output logic              running,
    output logic              halted,
    output logic [ADDR_W:0]   prog_len_o,
    output logic [15:0]       cycle_cnt_o,
    output logic [7:0]        checksum_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CMP_W = (LEN_W > 8) ? LEN_W : 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] prog_len_q, prog_len_d;
    logic [15:0]      cycle_q, cycle_d;
    logic             mem_we;
    logic             can_write;
    logic             pc_in_range;
    logic [5:0]       mem [DEPTH];

    assign can_write   = (state_q == S_LOAD) && (prog_len_q < LEN_W'(DEPTH));
    // Unsigned compare also catches a backward branch wrapping pc to a large value.
    assign pc_in_range = CMP_W'(pc_i) < CMP_W'(prog_len_q);

    // Next-state and register update selection; stop outranks load_start outranks run_start.
    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        cycle_d    = cycle_q;
        mem_we     = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        state_d    = S_LOAD;
                        prog_len_d = '0;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        prog_len_d = '0;
                    end else begin
                        if (wr_valid && can_write) begin
                            mem_we     = 1'b1;
                            prog_len_d = prog_len_q + LEN_W'(1);
                        end
                        if (run_start && (prog_len_d != '0)) begin
                            state_d = S_RUN;
                            cycle_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        state_d    = S_LOAD;
                        prog_len_d = '0;
                    end else begin
                        if (cycle_q != 16'hFFFF) begin
                            cycle_d = cycle_q + 16'd1;
                        end
                        if (!pc_in_range) begin
                            state_d = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (load_start) begin
                        state_d    = S_LOAD;
                        prog_len_d = '0;
                    end else if (run_start) begin
                        state_d = S_RUN;
                        cycle_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prog_len_q <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            prog_len_q <= prog_len_d;
            cycle_q    <= cycle_d;
        end
    end

    // Program storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[prog_len_q[ADDR_W-1:0]] <= wr_data;
        end
    end

`ifdef EZM_FEEDER_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst || (load_start && !stop)) begin
            checksum_q <= '0;
        end else if (mem_we) begin
            checksum_q <= checksum_q + 8'(wr_data);
        end
    end

    assign checksum_o = rst ? 8'h00 : checksum_q;
`else
    assign checksum_o = 8'h00;
`endif

    // Instruction path is zero-latency: the core samples in_i on the edge that advances pc.
    assign instr_o     = (!rst && (state_q == S_RUN) && pc_in_range)
                         ? mem[pc_i[ADDR_W-1:0]] : NOP_WORD;
    assign wr_ready    = !rst && can_write;
    assign cpu_rst_o   = rst || (state_q == S_IDLE) || (state_q == S_LOAD);
    assign running     = !rst && (state_q == S_RUN);
    assign halted      = !rst && (state_q == S_HALT);
    assign prog_len_o  = rst ? '0 : prog_len_q;
    assign cycle_cnt_o = rst ? '0 : cycle_q;

endmodule

// File: tb/tb_ezm_prog_feeder.sv
// Directed self-checking bench for ezm_prog_feeder (default ADDR_W=5, DEPTH=32).
module tb_ezm_prog_feeder;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        run_start;
    logic        stop;
    logic        wr_valid;
    logic [5:0]  wr_data;
    logic        wr_ready;
    logic [7:0]  pc_i;
    logic [5:0]  instr_o;
    logic        cpu_rst_o;
    logic        running;
    logic        halted;
    logic [5:0]  prog_len_o;
    logic [15:0] cycle_cnt_o;
    logic [7:0]  checksum_o;

    int checks;
    int failures;

    ezm_prog_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .run_start   (run_start),
        .stop        (stop),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .pc_i        (pc_i),
        .instr_o     (instr_o),
        .cpu_rst_o   (cpu_rst_o),
        .running     (running),
        .halted      (halted),
        .prog_len_o  (prog_len_o),
        .cycle_cnt_o (cycle_cnt_o),
        .checksum_o  (checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        load_start = 1'b0;
        run_start  = 1'b0;
        stop       = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 6'h00;
        pc_i       = 8'h00;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_cpu_rst",  32'(cpu_rst_o),   32'd1);
        check("rst_instr",    32'(instr_o),     32'h00);
        check("rst_wr_ready", 32'(wr_ready),    32'd0);
        check("rst_prog_len", 32'(prog_len_o),  32'd0);
        check("rst_cycle",    32'(cycle_cnt_o), 32'd0);
        rst = 1'b0;
        tick();

        // run_start ignored in IDLE
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("idle_run_ignored", 32'(running),   32'd0);
        check("idle_cpu_rst",     32'(cpu_rst_o), 32'd1);

        // Load three words and run them
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_wr_ready", 32'(wr_ready),  32'd1);
        check("load_cpu_rst",  32'(cpu_rst_o), 32'd1);
        wr_valid = 1'b1; wr_data = 6'b100011; tick();
        wr_data = 6'b001000; tick();
        wr_data = 6'b010000; tick();
        wr_valid = 1'b0;
        check("load3_len", 32'(prog_len_o), 32'd3);
        pc_i = 8'd0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("run_entered", 32'(running),     32'd1);
        check("run_cpu_rst", 32'(cpu_rst_o),   32'd0);
        check("run_cycle0",  32'(cycle_cnt_o), 32'd0);
        check("run_pc0",     32'(instr_o),     32'h23);
        tick();
        pc_i = 8'd1; #1;
        check("run_pc1", 32'(instr_o), 32'h08);
        tick();
        pc_i = 8'd2; #1;
        check("run_pc2", 32'(instr_o), 32'h10);
        tick();
        pc_i = 8'd3; #1;
        check("run_pc3_nop",  32'(instr_o), 32'h00);
        check("run_pc3_nohalt", 32'(halted), 32'd0);
        tick();
        check("halt_entered", 32'(halted),      32'd1);
        check("halt_cycle",   32'(cycle_cnt_o), 32'd4);
        check("halt_cpu_rst", 32'(cpu_rst_o),   32'd0);
        check("halt_instr",   32'(instr_o),     32'h00);
        tick();
        check("halt_cycle_frozen", 32'(cycle_cnt_o), 32'd4);

        // Restart from HALT with the same program
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("rerun_running", 32'(running),     32'd1);
        check("rerun_cycle0",  32'(cycle_cnt_o), 32'd0);
        check("rerun_len",     32'(prog_len_o),  32'd3);
        pc_i = 8'd1; #1;
        check("rerun_pc1", 32'(instr_o), 32'h08);
        pc_i = 8'd200; #1;
        check("rerun_wrap_nop", 32'(instr_o), 32'h00);
        tick();
        check("rerun_wrap_halt", 32'(halted), 32'd1);

        // Fill memory, extra writes dropped
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("reload_len0",    32'(prog_len_o), 32'd0);
        check("reload_cpu_rst", 32'(cpu_rst_o),  32'd1);
        wr_valid = 1'b1;
        for (int i = 0; i < 35; i++) begin
            wr_data = 6'(i + 1);
            tick();
            if (i == 30) check("fill31_ready", 32'(wr_ready), 32'd1);
            if (i == 31) check("fill32_notready", 32'(wr_ready), 32'd0);
        end
        wr_valid = 1'b0;
        check("fill_len", 32'(prog_len_o), 32'd32);
        pc_i = 8'd0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("fill_mem0", 32'(instr_o), 32'h01);
        pc_i = 8'd31; #1;
        check("fill_mem31", 32'(instr_o), 32'h20);
        pc_i = 8'd32; #1;
        check("fill_pc32_nop", 32'(instr_o), 32'h00);

        // Empty-program run_start ignored, then write+run same cycle
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_idle", 32'(running), 32'd0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("empty_run_not_running", 32'(running),   32'd0);
        check("empty_run_cpu_rst",     32'(cpu_rst_o), 32'd1);
        check("empty_run_still_load",  32'(wr_ready),  32'd1);
        pc_i = 8'd0;
        wr_valid = 1'b1; wr_data = 6'h2A; run_start = 1'b1;
        tick();
        wr_valid = 1'b0; run_start = 1'b0;
        check("wrrun_running", 32'(running),    32'd1);
        check("wrrun_len",     32'(prog_len_o), 32'd1);
        check("wrrun_instr",   32'(instr_o),    32'h2A);

        // Stop during RUN at cycle_cnt=10
        for (int i = 0; i < 10; i++) tick();
        check("run_cycle10", 32'(cycle_cnt_o), 32'd10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_running", 32'(running),    32'd0);
        check("stop_halted",  32'(halted),     32'd0);
        check("stop_cpu_rst", 32'(cpu_rst_o),  32'd1);
        check("stop_len",     32'(prog_len_o), 32'd1);
        check("stop_instr",   32'(instr_o),    32'h00);

        // Reset during LOAD
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 6'h05; tick();
        tick();
        wr_valid = 1'b0;
        check("midload_len", 32'(prog_len_o), 32'd2);
        rst = 1'b1;
        tick();
        check("rstload_len",      32'(prog_len_o), 32'd0);
        check("rstload_cpu_rst",  32'(cpu_rst_o),  32'd1);
        check("rstload_wr_ready", 32'(wr_ready),   32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(wr_ready), 32'd0);

        // Checksum of five 6'h3F words
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 6'h3F;
        for (int i = 0; i < 5; i++) tick();
        wr_valid = 1'b0;
        check("csum_len", 32'(prog_len_o), 32'd5);
`ifdef EZM_FEEDER_CHECKSUM_EN
        check("csum_value", 32'(checksum_o), 32'h3B);
`else
        check("csum_value", 32'(checksum_o), 32'h00);
`endif
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("csum_cleared", 32'(checksum_o), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
